uart_rx: RTL and testbench

- UART receive stage: the block directly downstream of the team's UART transmitter. Together with it, forms a serial loopback/link.
- Deserialises an asynchronous serial line into parallel bytes, using a 16x-baud oversampling tick as a clock enable.
- Presents each received byte on a valid/ack handshake and flags framing and overrun errors.
- Single clock domain; the tick is an enable sampled on clk, never used as a clock.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default frame
// geometry reused by the transmitter and the baud-tick generator.
package uart_pkg;

  localparam int UART_NBITS      = 8;   // data bits per frame
  localparam int UART_OVERSAMPLE = 16;  // ticks per bit period

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 (idle line level) so a reset never looks like a start bit.
//   clk   : system clock
//   reset : async active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (2 clk latency)
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= 2'b11;
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x (OVERSAMPLE) oversampled deserialiser with valid/ack
// output handshake, framing-error and overrun-error pulses.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN, which adds
// a PARITY state and the parity_err output.
//   clk         : system clock
//   reset       : async active-high reset
//   tick        : OVERSAMPLE x baud enable pulse
//   Rx          : async serial line, idle high
//   rx_ack      : consumer ack, honoured only while rx_valid
//   rx_data     : last good received byte
//   rx_valid    : byte available, cleared by rx_ack
//   frame_err   : 1-clk pulse, stop bit sampled low
//   overrun_err : 1-clk pulse, capture over an unacked byte
//   parity_err  : 1-clk pulse, parity mismatch (UART_RX_PARITY_EN only)
//   busy        : FSM not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBITS      = UART_NBITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             Rx,
  input  logic             rx_ack,
  output logic [NBITS-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NBITS) + 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (Rx),
    .q_o   (rx_s)
  );

  uart_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             oerr_q, oerr_d;
  logic             capture;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;   // parity bit as received
  logic             perr_q, perr_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      oerr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      oerr_q   <= oerr_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    oerr_d   = 1'b0;
    capture  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (tick && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (cnt_q == CNT_MID) begin
            // Re-check the line at mid start bit to reject glitches.
            if (!rx_s) begin
              state_d  = ST_DATA;
              cnt_d    = '0;
              bitcnt_d = '0;
            end else begin
              state_d  = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            // LSB arrives first, so shift right and let it settle at bit 0.
            shreg_d  = {rx_s, shreg_q[NBITS-1:1]};
            bitcnt_d = bitcnt_q + 1'b1;
            cnt_d    = '0;
            if (bitcnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s;
            cnt_d   = '0;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              capture = 1'b1;
              state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to 0.
              perr_d  = par_q != (^shreg_q);
`endif
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold here until the line releases so a long break errors once.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_ack && valid_q) valid_d = 1'b0;

    // A capture overrides the ack clear; an ack in the same clk absorbs the
    // pending byte, so only an unacked pending byte counts as overrun.
    if (capture) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      oerr_d  = valid_q && !rx_ack;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are built bit by bit at 16 ticks per bit,
// one tick every 4 clk. Error pulses are tallied by counters and compared as
// deltas around each scenario.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       Rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       bad_par = 1'b0;
  int         pe_n = 0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int fe_n = 0;
  int ov_n = 0;
  int fe0, ov0;

  always #5 clk = ~clk;

  uart_rx #(.NBITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .Rx          (Rx),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .busy        (busy)
  );

  always @(posedge clk) begin
    if (frame_err === 1'b1)   fe_n <= fe_n + 1;
    if (overrun_err === 1'b1) ov_n <= ov_n + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1)  pe_n <= pe_n + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick_pulse();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int nt);
    @(negedge clk) Rx = b;
    for (int i = 0; i < nt; i++) tick_pulse();
  endtask

  // Start bit, data LSB first, and parity bit when the feature is built in.
  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par, 16);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d);
    send_bit(1'b1, 16);
  endtask

  task automatic do_ack();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_oerr", overrun_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    send_bit(1'b1, 4);

    // 0xA5: stop sampled on the 10th stop tick (sync latency + mid-bit)
    fe0 = fe_n;
    send_head(8'hA5);
    send_bit(1'b1, 9);
    chk("a5_valid_before", rx_valid, 1'b0);
    chk("a5_busy_mid", busy, 1'b1);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("a5_valid_1clk", rx_valid, 1'b1);
    chk("a5_data", rx_data, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    send_bit(1'b1, 6);
    chk("a5_ferr", fe_n - fe0, 0);
    chk("a5_busy_after", busy, 1'b0);
    do_ack();
    chk("a5_ack_clears", rx_valid, 1'b0);
    do_ack();
    chk("ack_idle_ignored", rx_valid, 1'b0);

    // Glitch: 3 ticks low then high
    fe0 = fe_n; ov0 = ov_n;
    send_bit(1'b0, 3);
    send_bit(1'b1, 20);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_valid", rx_valid, 1'b0);
    chk("glitch_errs", (fe_n - fe0) + (ov_n - ov0), 0);
    send_frame(8'h3C);
    chk("3c_valid", rx_valid, 1'b1);
    chk("3c_data", rx_data, 8'h3C);
    do_ack();

    // Framing error with line held low for 40 ticks
    fe0 = fe_n;
    send_head(8'h3C);
    send_bit(1'b0, 40);
    chk("brk_ferr_once", fe_n - fe0, 1);
    chk("brk_busy", busy, 1'b1);
    chk("brk_valid", rx_valid, 1'b0);
    chk("brk_data", rx_data, 8'h3C);
    send_bit(1'b1, 4);
    chk("brk_release", busy, 1'b0);
    send_frame(8'h5A);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_valid", rx_valid, 1'b1);
    chk("5a_ferr_total", fe_n - fe0, 1);
    do_ack();

    // Overrun: two frames, no ack
    ov0 = ov_n;
    send_frame(8'h11);
    send_frame(8'h22);
    chk("ovr_count", ov_n - ov0, 1);
    chk("ovr_data", rx_data, 8'h22);
    chk("ovr_valid", rx_valid, 1'b1);
    do_ack();

    // Same pair with ack in the capture clk of 0x22
    ov0 = ov_n;
    send_frame(8'h11);
    send_head(8'h22);
    send_bit(1'b1, 9);
    @(negedge clk) begin tick = 1'b1; rx_ack = 1'b1; end
    @(negedge clk) begin tick = 1'b0; rx_ack = 1'b0; end
    chk("ack_cap_valid", rx_valid, 1'b1);
    chk("ack_cap_data", rx_data, 8'h22);
    @(negedge clk);
    @(negedge clk);
    send_bit(1'b1, 6);
    chk("ack_cap_no_ovr", ov_n - ov0, 0);
    do_ack();

    // Reset mid-frame after 4 data bits of 0xFF
    fe0 = fe_n; ov0 = ov_n;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    chk("mid_busy", busy, 1'b1);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 4);
    chk("mid_no_pulse", (fe_n - fe0) + (ov_n - ov0), 0);
    send_frame(8'h81);
    chk("81_data", rx_data, 8'h81);
    chk("81_valid", rx_valid, 1'b1);
    do_ack();

`ifdef UART_RX_PARITY_EN
    pe0_block: begin
      int pe0;
      pe0 = pe_n;
      send_frame(8'h07);
      chk("par_ok", pe_n - pe0, 0);
      chk("par_ok_data", rx_data, 8'h07);
      do_ack();
      bad_par = 1'b1;
      send_frame(8'h07);
      bad_par = 1'b0;
      chk("par_bad", pe_n - pe0, 1);
      chk("par_bad_data", rx_data, 8'h07);
      chk("par_bad_valid", rx_valid, 1'b1);
      do_ack();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
